// File: rtl/cdp1802_loader.sv
// Host-side image loader for a CDP1802 core: parses a byte stream ('L' load,
// 'G' go, 'H' halt), writes image bytes into RAM, then hands RAM to the CPU.
module cdp1802_loader (
    input  logic        clock,
    input  logic        reset,
    // Byte stream: a byte moves on any rising edge with in_valid=1 and in_ready=1.
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        cpu_resetq,
    input  logic        cpu_ram_rd,
    input  logic        cpu_ram_wr,
    input  logic [15:0] cpu_ram_a,
    input  logic [7:0]  cpu_ram_d,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_a,
    output logic [7:0]  mem_d,
    output logic        running,
    output logic        loading,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_HI,
        S_A_LO,
        S_L_HI,
        S_L_LO,
        S_DATA,
        S_RUN
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_GO   = 8'h47;
    localparam logic [7:0] CMD_HALT = 8'h48;

    state_t      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] len_q, len_d;
    logic        err_q, err_d;
    logic        running_q, running_d;
    logic        loading_q, loading_d;

    logic        xfer;
    logic        load_wr;
    logic [15:0] len_hdr;

    assign in_ready = ~reset;
    assign xfer     = in_valid & in_ready;
    assign load_wr  = xfer && (state_q == S_DATA);
    assign len_hdr  = {len_q[15:8], in_data};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        err_d   = err_q;
        if (xfer) begin
            case (state_q)
                S_IDLE: begin
                    case (in_data)
                        CMD_LOAD: state_d = S_A_HI;
                        CMD_GO:   state_d = S_RUN;
                        CMD_HALT: state_d = S_IDLE;
                        default:  err_d   = 1'b1;
                    endcase
                end
                S_A_HI: begin
                    ptr_d[15:8] = in_data;
                    state_d     = S_A_LO;
                end
                S_A_LO: begin
                    ptr_d[7:0] = in_data;
                    state_d    = S_L_HI;
                end
                S_L_HI: begin
                    len_d[15:8] = in_data;
                    state_d     = S_L_LO;
                end
                S_L_LO: begin
                    len_d   = len_hdr;
                    state_d = (len_hdr == 16'h0000) ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    // Pointer wraps naturally at 0xFFFF; wrapping is not an error.
                    ptr_d = ptr_q + 16'd1;
                    len_d = len_q - 16'd1;
                    if (len_q == 16'd1) state_d = S_IDLE;
                end
                S_RUN: begin
                    if (in_data == CMD_HALT) state_d = S_IDLE;
                    else                     err_d   = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
        running_d = (state_d == S_RUN);
        loading_d = (state_d == S_A_HI) || (state_d == S_A_LO) ||
                    (state_d == S_L_HI) || (state_d == S_L_LO) ||
                    (state_d == S_DATA);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= 16'h0000;
            len_q     <= 16'h0000;
            err_q     <= 1'b0;
            running_q <= 1'b0;
            loading_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            err_q     <= err_d;
            running_q <= running_d;
            loading_q <= loading_d;
        end
    end

    // RAM ownership follows the registered running flag; strobes are dead during reset.
    always_comb begin
        if (running_q) begin
            mem_rd = cpu_ram_rd & ~reset;
            mem_wr = cpu_ram_wr & ~reset;
            mem_a  = cpu_ram_a;
            mem_d  = cpu_ram_d;
        end else begin
            mem_rd = 1'b0;
            mem_wr = load_wr;
            mem_a  = ptr_q;
            mem_d  = in_data;
        end
    end

    assign cpu_resetq = running_q;
    assign running    = running_q;
    assign loading    = loading_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cdp1802_loader.sv
// Self-checking bench for cdp1802_loader: loader writes are scoreboarded
// against an expected queue of {address, data}; control outputs are checked inline.
module tb_cdp1802_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        cpu_resetq;
    logic        cpu_ram_rd = 1'b0;
    logic        cpu_ram_wr = 1'b0;
    logic [15:0] cpu_ram_a = 16'h0000;
    logic [7:0]  cpu_ram_d = 8'h00;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_a;
    logic [7:0]  mem_d;
    logic        running;
    logic        loading;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] exp_q[$];

    cdp1802_loader dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cpu_resetq (cpu_resetq),
        .cpu_ram_rd (cpu_ram_rd),
        .cpu_ram_wr (cpu_ram_wr),
        .cpu_ram_a  (cpu_ram_a),
        .cpu_ram_d  (cpu_ram_d),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_a      (mem_a),
        .mem_d      (mem_d),
        .running    (running),
        .loading    (loading),
        .err        (err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        logic [23:0] exp;
        if (!reset && !running) begin
            if (mem_wr) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_write: got %h@%h, required no write", mem_d, mem_a);
                end else begin
                    exp = exp_q.pop_front();
                    if ({mem_a, mem_d} !== exp) begin
                        n_fail++;
                        $display("FAIL sb_write: got %h@%h, required %h@%h",
                                 mem_d, mem_a, exp[7:0], exp[23:8]);
                    end
                end
            end
            if (mem_rd !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_mem_rd_idle: got %b, required 0", mem_rd);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drive starts 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            in_data = 8'($urandom_range(0, 255));
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic check_queue_empty(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: got %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        cpu_ram_rd = 1'b1;
        cpu_ram_wr = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        n_checks++;
        if ({in_ready, mem_wr, mem_rd} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_strobes: got ready/wr/rd=%b%b%b, required 000", in_ready, mem_wr, mem_rd);
        end
        n_checks++;
        if ({running, cpu_resetq, loading, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got run/rq/load/err=%b%b%b%b, required 0000",
                     running, cpu_resetq, loading, err);
        end
        cpu_ram_rd = 1'b0;
        cpu_ram_wr = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || mem_a !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b mem_a=%h, required 1 0000", in_ready, mem_a);
        end
    endtask

    task automatic test_load_basic();
        logic [7:0] hdr [5] = '{8'h4C, 8'h01, 8'h00, 8'h00, 8'h03};
        logic [7:0] dat [3] = '{8'hAA, 8'hBB, 8'hCC};
        for (int i = 0; i < 5; i++) send_byte(hdr[i]);
        n_checks++;
        if (loading !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_loading_hdr: got %b, required 1", loading);
        end
        for (int i = 0; i < 3; i++) push_exp(16'h0100 + 16'(i), dat[i]);
        for (int i = 0; i < 3; i++) send_byte(dat[i]);
        n_checks++;
        if (loading !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: got loading=%b err=%b, required 0 0", loading, err);
        end
        check_queue_empty("basic");
    endtask

    task automatic test_wrap();
        logic [7:0] s [7] = '{8'h4C, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22};
        push_exp(16'hFFFF, 8'h11);
        push_exp(16'h0000, 8'h22);
        for (int i = 0; i < 7; i++) send_byte(s[i]);
        n_checks++;
        if (loading !== 1'b0 || err !== 1'b0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_idle: got loading=%b err=%b running=%b, required 0 0 0", loading, err, running);
        end
        n_checks++;
        if (mem_a !== 16'h0001) begin
            n_fail++;
            $display("FAIL wrap_ptr: got mem_a=%h, required 0001", mem_a);
        end
        check_queue_empty("wrap");
    endtask

    task automatic test_zero_len_go();
        logic [7:0] s [5] = '{8'h4C, 8'h20, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) send_byte(s[i]);
        n_checks++;
        if (loading !== 1'b0 || mem_a !== 16'h2000) begin
            n_fail++;
            $display("FAIL zlen_idle: got loading=%b mem_a=%h, required 0 2000", loading, mem_a);
        end
        in_valid = 1'b1;
        in_data  = 8'h47;
        @(negedge clock);
        n_checks++;
        if (cpu_resetq !== 1'b0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL go_before: got cpu_resetq=%b running=%b, required 0 0", cpu_resetq, running);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (cpu_resetq !== 1'b1 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL go_after: got cpu_resetq=%b running=%b, required 1 1", cpu_resetq, running);
        end
        check_queue_empty("zlen");
    endtask

    task automatic test_run_mux();
        cpu_ram_a  = 16'h1234;
        cpu_ram_wr = 1'b1;
        cpu_ram_rd = 1'b0;
        cpu_ram_d  = 8'h5A;
        #1;
        n_checks++;
        if (mem_a !== 16'h1234 || mem_wr !== 1'b1 || mem_d !== 8'h5A || mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL run_mux_wr: got a=%h wr=%b d=%h rd=%b, required 1234 1 5a 0", mem_a, mem_wr, mem_d, mem_rd);
        end
        cpu_ram_rd = 1'b1;
        cpu_ram_wr = 1'b0;
        cpu_ram_a  = 16'($urandom_range(0, 65535));
        #1;
        n_checks++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_a !== cpu_ram_a) begin
            n_fail++;
            $display("FAIL run_mux_rd: got rd=%b wr=%b a=%h, required 1 0 %h", mem_rd, mem_wr, mem_a, cpu_ram_a);
        end
        send_byte(8'h4C);
        n_checks++;
        if (err !== 1'b1 || running !== 1'b1 || loading !== 1'b0) begin
            n_fail++;
            $display("FAIL run_bad_cmd: got err=%b running=%b loading=%b, required 1 1 0", err, running, loading);
        end
        cpu_ram_wr = 1'b1;
        send_byte(8'h48);
        n_checks++;
        if (cpu_resetq !== 1'b0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL halt: got cpu_resetq=%b running=%b, required 0 0", cpu_resetq, running);
        end
        n_checks++;
        if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || mem_a !== 16'h2000) begin
            n_fail++;
            $display("FAIL halt_block: got wr=%b rd=%b a=%h, required 0 0 2000", mem_wr, mem_rd, mem_a);
        end
        cpu_ram_wr = 1'b0;
        cpu_ram_rd = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_err_sticky: got %b, required 1", err);
        end
    endtask

    task automatic test_abort_reset();
        logic [7:0] s [6] = '{8'h4C, 8'h00, 8'h10, 8'h00, 8'h04, 8'h55};
        push_exp(16'h0010, 8'h55);
        for (int i = 0; i < 6; i++) send_byte(s[i]);
        idle_cycles(10);
        n_checks++;
        if (loading !== 1'b1 || mem_a !== 16'h0011) begin
            n_fail++;
            $display("FAIL abort_hold: got loading=%b mem_a=%h, required 1 0011", loading, mem_a);
        end
        check_queue_empty("abort");
        apply_reset(1);
        #1;
        n_checks++;
        if (loading !== 1'b0 || err !== 1'b0 || cpu_resetq !== 1'b0 || mem_a !== 16'h0000) begin
            n_fail++;
            $display("FAIL abort_after: got loading=%b err=%b rq=%b a=%h, required 0 0 0 0000",
                     loading, err, cpu_resetq, mem_a);
        end
    endtask

    task automatic test_err_then_load();
        logic [7:0] s [7] = '{8'h4C, 8'h03, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD};
        send_byte(8'h99);
        n_checks++;
        if (err !== 1'b1 || loading !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_idle_cmd: got err=%b loading=%b, required 1 0", err, loading);
        end
        send_byte(8'h48);
        push_exp(16'h0300, 8'hDE);
        push_exp(16'h0301, 8'hAD);
        for (int i = 0; i < 7; i++) send_byte(s[i]);
        n_checks++;
        if (err !== 1'b1 || loading !== 1'b0) begin
            n_fail++;
            $display("FAIL err_load_end: got err=%b loading=%b, required 1 0", err, loading);
        end
        check_queue_empty("errload");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            logic [15:0] addr;
            int          len;
            logic [7:0]  b;
            addr = 16'($urandom_range(0, 65535));
            len  = $urandom_range(1, 12);
            send_byte(8'h4C);
            send_byte(addr[15:8]);
            idle_cycles($urandom_range(0, 3));
            send_byte(addr[7:0]);
            send_byte(8'h00);
            send_byte(8'(len));
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(0, 255));
                push_exp(addr + 16'(i), b);
                send_byte(b);
                if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 4));
            end
            n_checks++;
            if (loading !== 1'b0 || mem_a !== addr + 16'(len)) begin
                n_fail++;
                $display("FAIL b2b_end: got loading=%b mem_a=%h, required 0 %h", loading, mem_a, addr + 16'(len));
            end
            check_queue_empty("b2b");
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        @(posedge clock);
        #1;
        test_load_basic();
        test_wrap();
        test_zero_len_go();
        test_run_mux();
        test_abort_reset();
        test_err_then_load();
        apply_reset(2);
        test_back_to_back();
        idle_cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
